// File: rtl/freq_ctrl_pkg.sv
// Shared definitions for the DDS frequency-control blocks: sweep FSM state
// encoding, default word widths and AD9911 register addresses.
package freq_ctrl_pkg;

  localparam int FW_W_DEFAULT = 32;
  localparam int DW_W_DEFAULT = 16;

  localparam logic [7:0] AD9911_CTW0_ADDR = 8'h04;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_REQ      = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_DWELL    = 3'd4,
    S_NEXT     = 3'd5
  } sweep_state_t;

endpackage

// File: rtl/freq_sweep_scheduler_if.sv
// Frequency-updater handshake: tuning word, update request/completion and
// the updater's initialisation-done flag.
interface freq_sweep_scheduler_if
  import freq_ctrl_pkg::*;
#(
  parameter int FW_W = FW_W_DEFAULT
);

  logic [FW_W-1:0] FREQW;
  logic            UPDATE;
  logic            UPDATED;
  logic            INITIED;

  modport master (
    output FREQW,
    output UPDATE,
    input  UPDATED,
    input  INITIED
  );

  modport slave (
    input  FREQW,
    input  UPDATE,
    output UPDATED,
    output INITIED
  );

endinterface

// File: rtl/sweep_step_calc.sv
// Next sweep point: one step toward stop, clamped to stop on overshoot or
// carry/borrow so the endpoint is always hit exactly.
module sweep_step_calc
  import freq_ctrl_pkg::*;
#(
  parameter int FW_W = FW_W_DEFAULT
) (
  input  logic [FW_W-1:0] cur,
  input  logic [FW_W-1:0] step,
  input  logic [FW_W-1:0] stop,
  input  logic            dir_up,
  output logic [FW_W-1:0] nxt,
  output logic            is_last
);

  logic [FW_W:0] sum;
  logic [FW_W:0] diff;

  always_comb begin
    sum     = {1'b0, cur} + {1'b0, step};
    diff    = {1'b0, cur} - {1'b0, step};
    // START==STOP is covered by cur==stop, since cur always begins at START
    is_last = (cur == stop) || (step == '0);
    if (dir_up) begin
      nxt = (sum[FW_W] || (sum[FW_W-1:0] > stop)) ? stop : sum[FW_W-1:0];
    end else begin
      nxt = (diff[FW_W] || (diff[FW_W-1:0] < stop)) ? stop : diff[FW_W-1:0];
    end
  end

endmodule

// File: rtl/freq_sweep_scheduler.sv
// Stepped frequency sweep sequencer: issues one tuning word per point over the
// UPDATE/UPDATED handshake and holds each point for a programmable dwell.
module freq_sweep_scheduler
  import freq_ctrl_pkg::*;
#(
  parameter int FW_W        = FW_W_DEFAULT,
  parameter int DW_W        = DW_W_DEFAULT,
  parameter int ACK_TIMEOUT = 4096
) (
  input  logic                   CLOCK_10M,
  input  logic                   RESET_N,
  input  logic                   START,
  input  logic                   ABORT,
  input  logic                   CONTINUOUS,
  input  logic [FW_W-1:0]        START_FW,
  input  logic [FW_W-1:0]        STOP_FW,
  input  logic [FW_W-1:0]        STEP_FW,
  input  logic [DW_W-1:0]        DWELL,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ERROR,
  output logic [DW_W-1:0]        STEP_IDX,
  freq_sweep_scheduler_if.master upd
);

  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

  sweep_state_t    state;
  sweep_state_t    state_nxt;

  logic            start_d;
  logic            updated_d;
  logic            start_rise;
  logic            ack_rise;
  logic            to_hit;
  logic            stop_req;

  logic            abort_q;
  logic            cont_l;
  logic            dir_up;
  logic            done_r;
  logic            error_r;
  logic [FW_W-1:0] start_l;
  logic [FW_W-1:0] stop_l;
  logic [FW_W-1:0] step_l;
  logic [FW_W-1:0] cur;
  logic [FW_W-1:0] freqw_r;
  logic [FW_W-1:0] nxt;
  logic            is_last;
  logic [DW_W-1:0] dwell_l;
  logic [DW_W-1:0] dwell_cnt;
  logic [DW_W-1:0] step_idx;
  logic [TO_W-1:0] to_cnt;

  assign start_rise = START & ~start_d;
  assign ack_rise   = upd.UPDATED & ~updated_d;
  assign to_hit     = (to_cnt == TO_W'(ACK_TIMEOUT - 1));
  assign stop_req   = ABORT | abort_q;

  sweep_step_calc #(.FW_W(FW_W)) u_step_calc (
    .cur     (cur),
    .step    (step_l),
    .stop    (stop_l),
    .dir_up  (dir_up),
    .nxt     (nxt),
    .is_last (is_last)
  );

  always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start_rise && upd.INITIED && !ABORT) state_nxt = S_LOAD;
      end
      S_LOAD:  state_nxt = S_REQ;
      S_REQ:   state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (ack_rise)    state_nxt = stop_req ? S_IDLE : S_DWELL;
        else if (to_hit) state_nxt = S_IDLE;
      end
      S_DWELL: begin
        // dwell of 0 and 1 both hold for a single cycle
        if (stop_req)                        state_nxt = S_IDLE;
        else if (dwell_cnt < DW_W'(2))       state_nxt = S_NEXT;
      end
      S_NEXT: begin
        if (stop_req)                  state_nxt = S_IDLE;
        else if (!is_last || cont_l)   state_nxt = S_REQ;
        else                           state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // losing the updater mid-sweep drops everything, including a live request
    if (state != S_IDLE && !upd.INITIED) state_nxt = S_IDLE;
  end

  always_comb begin
    BUSY       = (state != S_IDLE);
    upd.UPDATE = (state == S_WAIT_ACK);
    upd.FREQW  = freqw_r;
    DONE       = done_r;
    ERROR      = error_r;
    STEP_IDX   = step_idx;
  end

  always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
    if (!RESET_N) begin
      start_d   <= 1'b0;
      updated_d <= 1'b0;
      abort_q   <= 1'b0;
      cont_l    <= 1'b0;
      dir_up    <= 1'b0;
      done_r    <= 1'b0;
      error_r   <= 1'b0;
      start_l   <= '0;
      stop_l    <= '0;
      step_l    <= '0;
      cur       <= '0;
      freqw_r   <= '0;
      dwell_l   <= '0;
      dwell_cnt <= '0;
      step_idx  <= '0;
      to_cnt    <= '0;
    end else begin
      start_d   <= START;
      updated_d <= upd.UPDATED;
      done_r    <= (state == S_NEXT) && is_last && !cont_l && !stop_req && upd.INITIED;
      if (state != S_IDLE && ABORT) abort_q <= 1'b1;

      case (state)
        S_IDLE: begin
          abort_q <= 1'b0;
          if (state_nxt == S_LOAD) error_r <= 1'b0;
        end
        S_LOAD: begin
          start_l  <= START_FW;
          stop_l   <= STOP_FW;
          step_l   <= STEP_FW;
          dwell_l  <= DWELL;
          cont_l   <= CONTINUOUS;
          dir_up   <= (STOP_FW >= START_FW);
          cur      <= START_FW;
          step_idx <= '0;
        end
        S_REQ: begin
          freqw_r <= cur;
          to_cnt  <= '0;
        end
        S_WAIT_ACK: begin
          if (ack_rise) begin
            dwell_cnt <= dwell_l;
          end else if (to_hit) begin
            if (upd.INITIED) error_r <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_DWELL: begin
          if (dwell_cnt != '0) dwell_cnt <= dwell_cnt - 1'b1;
        end
        S_NEXT: begin
          if (state_nxt == S_REQ) begin
            if (!is_last) begin
              cur <= nxt;
              if (step_idx != '1) step_idx <= step_idx + 1'b1;
            end else begin
              cur      <= start_l;
              step_idx <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_sweep_scheduler.sv
// Randomised bench for freq_sweep_scheduler: a behavioural updater answers the
// handshake and recorded points are compared with an arithmetic sweep model.
module tb_freq_sweep_scheduler;

  typedef logic [31:0] fw_q_t [$];

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        continuous;
  logic [31:0] start_fw;
  logic [31:0] stop_fw;
  logic [31:0] step_fw;
  logic [15:0] dwell;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] step_idx;

  freq_sweep_scheduler_if #(.FW_W(32)) fif ();

  freq_sweep_scheduler #(.FW_W(32), .DW_W(16), .ACK_TIMEOUT(16)) dut (
    .CLOCK_10M  (clk),
    .RESET_N    (rst_n),
    .START      (start),
    .ABORT      (abort),
    .CONTINUOUS (continuous),
    .START_FW   (start_fw),
    .STOP_FW    (stop_fw),
    .STEP_FW    (step_fw),
    .DWELL      (dwell),
    .BUSY       (busy),
    .DONE       (done),
    .ERROR      (error),
    .STEP_IDX   (step_idx),
    .upd        (fif)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // behavioural updater: raises UPDATED after ack_dly samples of UPDATE high
  int ack_dly = 3;
  bit ack_en  = 1'b1;
  initial begin
    int hi;
    hi = 0;
    fif.UPDATED = 1'b0;
    forever begin
      @(negedge clk);
      if (fif.UPDATE) begin
        hi++;
        if (ack_en && hi == ack_dly) fif.UPDATED = 1'b1;
      end else begin
        hi = 0;
        fif.UPDATED = 1'b0;
      end
    end
  end

  fw_q_t       got_fw;
  logic [15:0] got_idx [$];
  int          gaps [$];
  int          done_cnt;
  int          fw_unstable;
  int          hi_len_last;
  bit          have_prev;

  initial begin
    bit          upd_prev;
    int          low_cnt;
    int          hi_m;
    logic [31:0] fw_hold;
    upd_prev = 1'b0; low_cnt = 0; hi_m = 0; fw_hold = '0;
    forever begin
      @(negedge clk);
      if (fif.UPDATE && !upd_prev) begin
        got_fw.push_back(fif.FREQW);
        got_idx.push_back(step_idx);
        if (have_prev) gaps.push_back(low_cnt);
        have_prev = 1'b1;
        low_cnt   = 0;
        fw_hold   = fif.FREQW;
      end
      if (fif.UPDATE) begin
        hi_m++;
        if (fif.FREQW != fw_hold) fw_unstable++;
      end else begin
        if (upd_prev) hi_len_last = hi_m;
        hi_m = 0;
        low_cnt++;
      end
      if (done) done_cnt++;
      upd_prev = fif.UPDATE;
    end
  end

  task automatic clear_mon();
    got_fw.delete();
    got_idx.delete();
    gaps.delete();
    done_cnt    = 0;
    fw_unstable = 0;
    hi_len_last = 0;
    have_prev   = 1'b0;
  endtask

  function automatic fw_q_t model_points(input logic [31:0] s, input logic [31:0] e,
                                         input logic [31:0] st);
    fw_q_t  q;
    longint c, stop_v, step_v, start_v;
    c = {32'b0, s}; start_v = c; stop_v = {32'b0, e}; step_v = {32'b0, st};
    while (1) begin
      q.push_back(c[31:0]);
      if (c == stop_v || step_v == 0 || q.size() > 4096) break;
      if (stop_v >= start_v) begin
        c = c + step_v;
        if (c > stop_v) c = stop_v;
      end else begin
        c = c - step_v;
        if (c < stop_v) c = stop_v;
      end
    end
    return q;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk); #2;
    @(negedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #2;
      if (!busy) return;
    end
    check_eq({tag, "_idle_timeout"}, busy, 0);
  endtask

  task automatic wait_reqs(input string tag, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (got_fw.size() >= n) return;
      @(negedge clk); #2;
    end
    check_eq({tag, "_req_timeout"}, got_fw.size(), n);
  endtask

  task automatic wait_upd_low(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!fif.UPDATE) return;
      @(negedge clk); #2;
    end
    check_eq({tag, "_fall_timeout"}, fif.UPDATE, 0);
  endtask

  task automatic run_sweep(input string tag, input logic [31:0] s, input logic [31:0] e,
                           input logic [31:0] st, input logic [15:0] dw, input int dly);
    fw_q_t exp_q;
    int    n;
    int    g;
    exp_q      = model_points(s, e, st);
    start_fw   = s;
    stop_fw    = e;
    step_fw    = st;
    dwell      = dw;
    continuous = 1'b0;
    ack_dly    = dly;
    clear_mon();
    pulse_start();
    // parameters are latched by now; later input activity must be ignored
    start_fw   = $urandom;
    stop_fw    = $urandom;
    step_fw    = $urandom;
    dwell      = 16'($urandom);
    continuous = 1'($urandom);
    wait_idle(tag, 20000);
    check_eq({tag, "_npts"}, got_fw.size(), exp_q.size());
    n = (got_fw.size() < exp_q.size()) ? got_fw.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_fw%0d", tag, i), got_fw[i], exp_q[i]);
      check_eq($sformatf("%s_idx%0d", tag, i), got_idx[i], i);
    end
    g = (dw == 0) ? 3 : int'(dw) + 2;
    foreach (gaps[i]) check_eq($sformatf("%s_gap%0d", tag, i), gaps[i], g);
    check_eq({tag, "_done"}, done_cnt, 1);
    check_eq({tag, "_fw_stable"}, fw_unstable, 0);
    check_eq({tag, "_error"}, error, 0);
  endtask

  initial begin
    #(100 * 90000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s, e, st, span;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; continuous = 1'b0;
    start_fw = '0; stop_fw = '0; step_fw = '0; dwell = '0;
    fif.INITIED = 1'b1;
    clear_mon();
    repeat (3) @(negedge clk);
    #2;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_update", fif.UPDATE, 0);
    check_eq("rst_freqw", fif.FREQW, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_error", error, 0);
    check_eq("rst_idx", step_idx, 0);
    rst_n = 1'b1;
    @(negedge clk); #2;

    run_sweep("up",     32'd1000, 32'd1300, 32'd100, 16'd5, 3);
    run_sweep("down",   32'd1000, 32'd750,  32'd100, 16'd5, 3);
    run_sweep("wrap",   32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 16'd1, 2);
    run_sweep("step0",  32'd4242, 32'd9000, 32'd0,   16'd0, 1);
    run_sweep("single", 32'd777,  32'd777,  32'd50,  16'd2, 4);

    for (int r = 0; r < 8; r++) begin
      s    = $urandom;
      span = $urandom_range(0, 3000);
      if ($urandom_range(0, 1) == 1) e = (s > 32'hFFFF_FFFF - span) ? 32'hFFFF_FFFF : s + span;
      else                           e = (s < span) ? 32'd0 : s - span;
      case ($urandom_range(0, 3))
        0:       st = 32'd0;
        1:       st = $urandom;
        default: st = span / $urandom_range(1, 10) + $urandom_range(0, 50);
      endcase
      run_sweep($sformatf("rnd%0d", r), s, e, st, 16'($urandom_range(0, 4)), $urandom_range(1, 4));
    end

    // continuous 10,20,10,... aborted while a request is outstanding
    start_fw = 32'd10; stop_fw = 32'd20; step_fw = 32'd10; dwell = 16'd2;
    continuous = 1'b1; ack_dly = 3;
    clear_mon();
    pulse_start();
    wait_reqs("cont", 5, 2000);
    abort = 1'b1;
    wait_idle("cont", 200);
    abort = 1'b0;
    check_eq("cont_npts", got_fw.size(), 5);
    for (int i = 0; i < 5 && i < got_fw.size(); i++) begin
      check_eq($sformatf("cont_fw%0d", i), got_fw[i], (i % 2 == 0) ? 10 : 20);
      check_eq($sformatf("cont_idx%0d", i), got_idx[i], i % 2);
    end
    foreach (gaps[i]) check_eq($sformatf("cont_gap%0d", i), gaps[i], 4);
    check_eq("cont_last_hi", hi_len_last, 3);
    check_eq("cont_done", done_cnt, 0);
    check_eq("cont_update", fif.UPDATE, 0);

    // abort during dwell
    start_fw = 32'd1000; stop_fw = 32'd1300; step_fw = 32'd100; dwell = 16'd10;
    continuous = 1'b0; ack_dly = 2;
    clear_mon();
    pulse_start();
    wait_reqs("abdw", 1, 200);
    wait_upd_low("abdw", 200);
    abort = 1'b1;
    @(negedge clk); #2;
    check_eq("abdw_busy", busy, 0);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check_eq("abdw_npts", got_fw.size(), 1);
    check_eq("abdw_done", done_cnt, 0);

    // acknowledge timeout, then recovery clears ERROR
    start_fw = 32'd500; stop_fw = 32'd600; step_fw = 32'd100; dwell = 16'd1;
    ack_en = 1'b0;
    clear_mon();
    pulse_start();
    wait_idle("tmo", 500);
    check_eq("tmo_hi_len", hi_len_last, 16);
    check_eq("tmo_error", error, 1);
    check_eq("tmo_busy", busy, 0);
    check_eq("tmo_update", fif.UPDATE, 0);
    check_eq("tmo_done", done_cnt, 0);
    check_eq("tmo_npts", got_fw.size(), 1);
    ack_en = 1'b1;
    clear_mon();
    pulse_start();
    check_eq("tmo_err_clr", error, 0);
    wait_idle("tmo2", 2000);
    check_eq("tmo2_npts", got_fw.size(), 2);
    check_eq("tmo2_done", done_cnt, 1);

    // updater loses initialisation during a request
    ack_en = 1'b0;
    clear_mon();
    pulse_start();
    wait_reqs("init", 1, 200);
    fif.INITIED = 1'b0;
    @(negedge clk); #2;
    check_eq("init_update", fif.UPDATE, 0);
    check_eq("init_busy", busy, 0);
    check_eq("init_error", error, 0);
    check_eq("init_done", done_cnt, 0);

    // START ignored while the updater is not initialised
    clear_mon();
    pulse_start();
    repeat (4) @(negedge clk);
    #2;
    check_eq("noinit_busy", busy, 0);
    check_eq("noinit_npts", got_fw.size(), 0);
    fif.INITIED = 1'b1;
    ack_en = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check_eq("noinit_busy2", busy, 0);

    // asynchronous reset in the middle of a dwell
    start_fw = 32'd1000; stop_fw = 32'd1300; step_fw = 32'd100; dwell = 16'd20;
    ack_dly = 2;
    clear_mon();
    pulse_start();
    wait_reqs("arst", 1, 200);
    wait_upd_low("arst", 200);
    repeat (3) @(negedge clk);
    #2;
    check_eq("arst_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_update", fif.UPDATE, 0);
    check_eq("arst_freqw", fif.FREQW, 0);
    check_eq("arst_done", done, 0);
    check_eq("arst_error", error, 0);
    check_eq("arst_idx", step_idx, 0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
